// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback stage of the 5-stage MIPS pipeline.
//
// Purpose: accepts retiring instructions from the memory stage over a
// valid/ready handshake, waits for load data on LW, and drives one registered,
// single-cycle register-file write per retiring instruction. Writes to $0 are
// always suppressed here.
//
// Optional feature (macro WB_RETIRE_CNT_EN):
//   defined   -> retire_cnt counts retired instructions (wraps at 2^CNT_W)
//   undefined -> retire_cnt tied to 0, no counter flops
//
// Ports:
//   clk          clock
//   reset        asynchronous assert, synchronous release, active-low
//   m_valid      memory stage offers an instruction
//   m_ready      writeback can accept (low only while waiting for load data)
//   m_instr      instruction being retired
//   m_alu        ALU result for m_instr
//   mem_rvalid   load data valid
//   mem_rdata    load data
//   write        register-file write enable, one cycle per write
//   wb_addr      destination register
//   rd_i         write data
//   err          sticky load-timeout flag
//   retire_cnt   retired-instruction count
// -----------------------------------------------------------------------------
package definitions;
    typedef logic [31:0] Instruction;
    typedef logic [31:0] Register;
    typedef enum logic {DISABLE = 1'b0, ENABLE = 1'b1} Signal;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] J     = 6'b000010;
endpackage

module wb_stage
    import definitions::*;
#(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_valid,
    output logic             m_ready,
    input  Instruction       m_instr,
    input  Register          m_alu,
    input  logic             mem_rvalid,
    input  Register          mem_rdata,
    output Signal            write,
    output logic [4:0]       wb_addr,
    output Register          rd_i,
    output logic             err,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {IDLE, COMMIT, WAIT_LOAD} state_t;

    // Counter only needs to reach LOAD_TIMEOUT-1; the timeout fires on the
    // cycle that would take it to LOAD_TIMEOUT.
    localparam int TW = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'((LOAD_TIMEOUT == 0) ? 0 : LOAD_TIMEOUT - 1);

    state_t        r_state, w_state_nxt;
    Signal         r_write, w_write_nxt;
    logic [4:0]    r_addr, w_addr_nxt;
    logic [4:0]    r_ld_dest, w_ld_dest_nxt;
    Register       r_data, w_data_nxt;
    logic          r_err, w_err_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    logic          w_xfer;
    logic          w_drop;
    logic [5:0]    w_op;
    logic [4:0]    w_rt;
    logic [4:0]    w_rd;
    logic          w_unused;

    assign w_op     = m_instr[31:26];
    assign w_rt     = m_instr[20:16];
    assign w_rd     = m_instr[15:11];
    assign w_unused = &{1'b0, m_instr[25:21], m_instr[10:0]};

    assign m_ready = (r_state != WAIT_LOAD);
    assign w_xfer  = m_valid && m_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_write_nxt   = DISABLE;
        w_addr_nxt    = r_addr;
        w_ld_dest_nxt = r_ld_dest;
        w_data_nxt    = r_data;
        w_err_nxt     = r_err;
        w_tcnt_nxt    = r_tcnt;
        w_drop        = 1'b0;
        case (r_state)
            IDLE, COMMIT: begin
                if (w_xfer) begin
                    if (w_op == LW) begin
                        // The load destination is parked separately so that
                        // wb_addr keeps showing the previous write while waiting.
                        w_state_nxt   = WAIT_LOAD;
                        w_ld_dest_nxt = w_rt;
                        w_tcnt_nxt    = '0;
                    end else begin
                        w_state_nxt = COMMIT;
                        w_addr_nxt  = w_rd;
                        w_data_nxt  = m_alu;
                        w_write_nxt = (w_op == RTYPE && w_rd != 5'd0) ? ENABLE : DISABLE;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_LOAD: begin
                // Data takes priority over a timeout landing in the same cycle.
                if (mem_rvalid) begin
                    w_state_nxt = COMMIT;
                    w_addr_nxt  = r_ld_dest;
                    w_data_nxt  = mem_rdata;
                    w_write_nxt = (r_ld_dest != 5'd0) ? ENABLE : DISABLE;
                end else if (LOAD_TIMEOUT != 0 && r_tcnt == TO_LAST) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                    w_drop      = 1'b1;
                end else if (LOAD_TIMEOUT != 0) begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_write   <= DISABLE;
            r_addr    <= '0;
            r_ld_dest <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_tcnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_write   <= w_write_nxt;
            r_addr    <= w_addr_nxt;
            r_ld_dest <= w_ld_dest_nxt;
            r_data    <= w_data_nxt;
            r_err     <= w_err_nxt;
            r_tcnt    <= w_tcnt_nxt;
        end
    end

    assign write   = r_write;
    assign wb_addr = r_addr;
    assign rd_i    = r_data;
    assign err     = r_err;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Every COMMIT cycle is one retirement; dropped loads also retire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == COMMIT || w_drop) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign retire_cnt = r_cnt;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
    assign retire_cnt    = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
// Stimulus tasks push expected register-file writes (cycle, address, data)
// into a queue; a monitor on the falling edge pops and compares whenever the
// DUT raises write, and flags writes that are missing or unexpected.
// -----------------------------------------------------------------------------
module tb_wb_stage;
    import definitions::*;

    localparam int TO = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m_valid = 1'b0;
    logic          m_ready;
    logic [31:0]   m_instr = '0;
    logic [31:0]   m_alu = '0;
    logic          mem_rvalid = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          write;
    logic [4:0]    wb_addr;
    logic [31:0]   rd_i;
    logic          err;
    logic [CW-1:0] retire_cnt;

    wb_stage #(.LOAD_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_instr    (m_instr),
        .m_alu      (m_alu),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .write      (write),
        .wb_addr    (wb_addr),
        .rd_i       (rd_i),
        .err        (err),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_ret = 0;
    logic err_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.cyc = c;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    // Monitor: one line per observed write.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (write === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h", cyc, wb_addr, rd_i);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("write cyc=%0d addr=%0d data=%h", cyc, wb_addr, rd_i);
                    chk("write_cycle", cyc, e.cyc);
                    chk("write_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                    chk("write_data", rd_i, e.data);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_write cyc=%0d expected_cyc=%0d addr=%0d data=%h",
                         cyc, e.cyc, e.addr, e.data);
            end
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        logic [31:0] r;
        r = $urandom;
        r[31:26] = op;
        r[20:16] = rt;
        r[15:11] = rd;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge. Returns the transfer edge index.
    task automatic issue(input logic [31:0] instr, input logic [31:0] alu, input bit push,
                         output int e_cyc, output int waits);
        m_valid = 1'b1;
        m_instr = instr;
        m_alu   = alu;
        waits   = 0;
        while (m_ready !== 1'b1 && waits < 20) begin
            tick();
            waits++;
        end
        if (m_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_ready_timeout cyc=%0d actual=%b expected=1", cyc, m_ready);
        end
        tick();
        e_cyc   = cyc;
        m_valid = 1'b0;
        n_ret++;
        $display("xfer cyc=%0d instr=%h alu=%h", e_cyc, instr, alu);
        if (push && instr[31:26] == RTYPE && instr[15:11] != 5'd0)
            push_exp(e_cyc, instr[15:11], alu);
    endtask

    // LW whose data arrives after d WAIT_LOAD cycles without mem_rvalid.
    task automatic do_lw(input logic [4:0] rt, input int d, input logic [31:0] data);
        int e_cyc;
        int w;
        mem_rvalid = 1'b0;
        issue(mk(LW, rt, 5'($urandom)), $urandom, 1'b0, e_cyc, w);
        for (int i = 0; i < d; i++) begin
            if (i < TO) chk("lw_ready_low", {31'd0, m_ready}, 32'd0);
            mem_rdata = $urandom;
            tick();
        end
        if (d < TO) begin
            chk("lw_ready_low", {31'd0, m_ready}, 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = data;
            if (rt != 5'd0) push_exp(cyc + 1, rt, data);
            tick();
            mem_rvalid = 1'b0;
        end else begin
            err_exp = 1'b1;
            chk("timeout_ready", {31'd0, m_ready}, 32'd1);
            chk("timeout_err", {31'd0, err}, 32'd1);
        end
    endtask

    task automatic settle();
        tick();
        tick();
        chk("idle_write", {31'd0, write}, 32'd0);
        chk("err_flag", {31'd0, err}, {31'd0, err_exp});
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", {16'd0, retire_cnt}, {16'd0, CW'(n_ret)});
`else
        chk("retire_cnt", {16'd0, retire_cnt}, 32'd0);
`endif
        chk("queue_drained", q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e_cyc;
        int w;
        logic [5:0] op;

        // Reset held with activity on the inputs.
        reset      = 1'b0;
        m_valid    = 1'b1;
        m_instr    = mk(RTYPE, 5'd1, 5'd5);
        m_alu      = 32'h5555_5555;
        mem_rvalid = 1'b1;
        tick();
        tick();
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_rd_i", rd_i, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cnt", {16'd0, retire_cnt}, 32'd0);
        chk("rst_ready", {31'd0, m_ready}, 32'd1);
        m_valid    = 1'b0;
        mem_rvalid = 1'b0;
        reset      = 1'b1;
        tick();

        // Single RTYPE, then write must drop the following cycle.
        issue(mk(RTYPE, 5'd2, 5'd5), 32'hAAAA_AAAA, 1'b1, e_cyc, w);
        tick();
        chk("single_write_drop", {31'd0, write}, 32'd0);
        chk("hold_addr", {27'd0, wb_addr}, 32'd5);
        chk("hold_data", rd_i, 32'hAAAA_AAAA);

        // Back-to-back RTYPE: second must be accepted with no stall.
        issue(mk(RTYPE, 5'd1, 5'd3), 32'h0000_0333, 1'b1, e_cyc, w);
        issue(mk(RTYPE, 5'd1, 5'd7), 32'h0000_0777, 1'b1, e_cyc, w);
        chk("b2b_no_stall", w, 32'd0);
        settle();

        // Stray mem_rvalid before the LW is ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        do_lw(5'd4, 3, 32'h1234_5678);
        settle();

        // Suppressed writes.
        issue(mk(RTYPE, 5'd3, 5'd0), 32'hFFFF_FFFF, 1'b1, e_cyc, w);
        issue(mk(SW, 5'd3, 5'd9), 32'h1111_1111, 1'b1, e_cyc, w);
        issue(mk(BEQ, 5'd3, 5'd9), 32'h2222_2222, 1'b1, e_cyc, w);
        issue(mk(J, 5'd3, 5'd9), 32'h3333_3333, 1'b1, e_cyc, w);
        do_lw(5'd0, 1, 32'h4444_4444);
        settle();

        // Data arriving on the last possible cycle beats the timeout.
        do_lw(5'd10, TO - 1, 32'hCAFE_0001);
        settle();

        // Timeouts, then normal operation with err sticky.
        do_lw(5'd6, TO, 32'h0);
        do_lw(5'd9, TO + 2, 32'h0);
        issue(mk(RTYPE, 5'd0, 5'd12), 32'h0000_0C0C, 1'b1, e_cyc, w);
        settle();

        // Randomized mix.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                mem_rvalid = 1'($urandom);
                mem_rdata  = $urandom;
                tick();
                mem_rvalid = 1'b0;
            end
            case ($urandom_range(0, 5))
                0, 1: issue(mk(RTYPE, 5'($urandom), 5'($urandom_range(0, 31))), $urandom, 1'b1, e_cyc, w);
                2: do_lw(5'($urandom_range(0, 31)), $urandom_range(0, TO + 2), $urandom);
                3: issue(mk(SW, 5'($urandom), 5'($urandom)), $urandom, 1'b1, e_cyc, w);
                4: issue(mk(BEQ, 5'($urandom), 5'($urandom)), $urandom, 1'b1, e_cyc, w);
                default: begin
                    op = 6'($urandom_range(1, 63));
                    if (op == LW) op = J;
                    issue(mk(op, 5'($urandom), 5'($urandom)), $urandom, 1'b1, e_cyc, w);
                end
            endcase
        end
        settle();

        // Asynchronous reset during a COMMIT cycle clears outputs at once.
        issue(mk(RTYPE, 5'd1, 5'd9), 32'h9999_9999, 1'b0, e_cyc, w);
        #1;
        reset = 1'b0;
        #1;
        chk("async_write", {31'd0, write}, 32'd0);
        chk("async_addr", {27'd0, wb_addr}, 32'd0);
        chk("async_rd_i", rd_i, 32'd0);
        chk("async_err", {31'd0, err}, 32'd0);
        chk("async_cnt", {16'd0, retire_cnt}, 32'd0);
        tick();
        reset   = 1'b1;
        n_ret   = 0;
        err_exp = 1'b0;
        tick();

        // Reset during WAIT_LOAD abandons the load.
        issue(mk(LW, 5'd4, 5'd0), 32'h0, 1'b0, e_cyc, w);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'd0, m_ready}, 32'd1);
        tick();
        reset      = 1'b1;
        n_ret      = 0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        tick();
        mem_rvalid = 1'b0;
        issue(mk(RTYPE, 5'd1, 5'd31), 32'h7777_0031, 1'b1, e_cyc, w);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage MIPS pipeline: the register-file write side that feeds the decode stage's write port (write, rd_i).
- Accepts retiring instructions from the memory stage over a valid/ready handshake and waits for load data on LW.
- Drives one registered, single-cycle register-file write per retiring instruction, and enforces $zero.
- Uses definitions package types (Instruction, Register, Signal) and opcodes (RTYPE, LW, SW, BEQ, J).

Parameters:
- LOAD_TIMEOUT, 16: cycles WAIT_LOAD waits for mem_rvalid before dropping the load; 0 = wait forever.
- CNT_W, 32: width of retire_cnt.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- m_valid  in  1  memory stage offers an instruction
- m_ready  out  1  writeback can accept
- m_instr  in  32  Instruction being retired
- m_alu  in  32  Register ALU result for m_instr
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  Register load data
- write  out  1  Signal; register-file write enable, one cycle per write
- wb_addr  out  5  destination register
- rd_i  out  32  Register write data
- err  out  1  sticky load-timeout flag
- retire_cnt  out  CNT_W  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, write=DISABLE, wb_addr=0, rd_i=0, err=0, retire_cnt=0, timeout counter=0.
  - Reset mid-WAIT_LOAD abandons the load with no write.
- States: IDLE, COMMIT, WAIT_LOAD.
- Handshake:
  - m_ready = 1 in IDLE and COMMIT, 0 in WAIT_LOAD; combinational from state only.
  - Transfer happens when m_valid && m_ready at a rising edge. m_instr and m_alu are sampled only on transfer.
- Decode on transfer:
  - RTYPE: dest = instr[15:11], data = m_alu, next state COMMIT.
  - LW: dest = instr[20:16], next state WAIT_LOAD, timeout counter cleared.
  - SW, BEQ, J and any other opcode: retire with no write, next state COMMIT with the write suppressed.
- COMMIT (exactly one cycle):
  - write=ENABLE only if the instruction writes and dest != 0; otherwise DISABLE, and wb_addr/rd_i still show the captured values.
  - From COMMIT: if a transfer occurs in the same cycle, go to the new instruction's next state (back-to-back throughput 1/cycle); else go to IDLE.
- Latency: transfer at edge k gives write high during the cycle after edge k. For LW, mem_rvalid sampled at edge j gives write high during the cycle after edge j.
- Outside COMMIT: write=DISABLE; wb_addr and rd_i hold their last values.
- WAIT_LOAD:
  - mem_rvalid=1: capture mem_rdata, go to COMMIT.
  - mem_rvalid outside WAIT_LOAD is ignored.
  - The timeout counter increments each cycle without mem_rvalid. When it reaches LOAD_TIMEOUT (nonzero): err<=1, go to IDLE, no write, the instruction still counts as retired.
  - If mem_rvalid arrives in the same cycle the counter reaches LOAD_TIMEOUT, the data wins and there is no error.
- err: stays 1 until reset.
- Write to $0: always suppressed here; the register file need not special-case it.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: retire_cnt increments by 1 on every cycle in COMMIT and on every timeout drop; wraps modulo 2^CNT_W.
- Undefined: retire_cnt tied to 0; no counter flops; port still present.

Test Plan:
- Reset checks:
  - Hold reset=0 for 2 cycles with m_valid=1 -> write=0, wb_addr=0, rd_i=0, err=0, retire_cnt=0.
  - Assert reset=0 mid-cycle -> all outputs clear immediately.
- RTYPE rd=5, m_alu=32'hAAAAAAAA, m_valid pulsed 1 cycle -> next cycle write=1, wb_addr=5, rd_i=AAAAAAAA; following cycle write=0.
- Back-to-back RTYPE rd=3 then rd=7 on consecutive cycles -> write=1 two cycles in a row with wb_addr 3 then 7; m_ready stays 1.
- LW rt=4, mem_rvalid asserted 3 cycles later with mem_rdata=32'h12345678:
  - m_ready=0 for those 3 cycles.
  - Then write=1, wb_addr=4, rd_i=12345678.
  - A mem_rvalid pulse issued before the LW has no effect.
- Suppressed writes:
  - RTYPE rd=0 -> write stays 0.
  - SW then BEQ -> write stays 0; retire_cnt=2 with WB_RETIRE_CNT_EN defined.
- Timeout: LOAD_TIMEOUT=4, LW with no mem_rvalid -> after 4 WAIT_LOAD cycles err=1, m_ready=1, no write. A later RTYPE still writes normally and err stays 1.
